// File: rtl/raymarch_scheduler.sv
// raymarch_scheduler: walks pixel coordinates in raster order and streams raymarcher results to a framebuffer as RGB565
module raymarch_scheduler #(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720
) (
  input  logic                             clk_pixel_in,
  input  logic                             rst_in,
  input  logic                             enable_in,
  input  logic                             pixel_done_in,
  input  logic [7:0]                       red_in,
  input  logic [7:0]                       green_in,
  input  logic [7:0]                       blue_in,
  output logic [$clog2(WIDTH)-1:0]         curr_x,
  output logic [$clog2(HEIGHT)-1:0]        curr_y,
  output logic                             fb_we_out,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]  fb_addr_out,
  output logic [15:0]                      fb_data_out,
  output logic                             frame_done_out,
  output logic [15:0]                      frame_count_out
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int AW = $clog2(WIDTH*HEIGHT);
  typedef enum logic [1:0] {PRIME, RUN, HOLD} state_t;
  state_t        state_q;
  logic [AW-1:0] addr_q;
  logic          x_last, y_last;
  assign x_last = curr_x == XW'(WIDTH - 1);
  assign y_last = curr_y == YW'(HEIGHT - 1);
  // Frame FSM: PRIME drops the stale first result, RUN writes one pixel per done pulse and advances, HOLD idles at (0,0)
  always_ff @(posedge clk_pixel_in or posedge rst_in)
    if (rst_in) begin
      state_q         <= PRIME;
      curr_x          <= '0;
      curr_y          <= '0;
      addr_q          <= '0;
      fb_we_out       <= 1'b0;
      fb_addr_out     <= '0;
      fb_data_out     <= '0;
      frame_done_out  <= 1'b0;
      frame_count_out <= '0;
    end else begin
      fb_we_out      <= 1'b0;
      frame_done_out <= 1'b0;
      case (state_q)
        PRIME: if (pixel_done_in) state_q <= enable_in ? RUN : HOLD;
        HOLD:  if (enable_in) state_q <= RUN;
        default: if (pixel_done_in) begin
          fb_we_out   <= 1'b1;
          fb_addr_out <= addr_q;
          fb_data_out <= {red_in[7:3], green_in[7:2], blue_in[7:3]};
          curr_x      <= x_last ? '0 : curr_x + 1'b1;
          if (x_last) curr_y <= y_last ? '0 : curr_y + 1'b1;
          addr_q      <= (x_last && y_last) ? '0 : addr_q + 1'b1;
          if (x_last && y_last) begin
            frame_done_out  <= 1'b1;
            frame_count_out <= frame_count_out + 16'd1;
            if (!enable_in) state_q <= HOLD;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_raymarch_scheduler.sv
// tb_raymarch_scheduler: directed checks of the raymarch scheduler on a 4x2 frame
module tb_raymarch_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        pixel_done = 1'b0;
  logic [7:0]  red = '0, green = '0, blue = '0;
  logic [1:0]  curr_x;
  logic        curr_y;
  logic        fb_we;
  logic [2:0]  fb_addr;
  logic [15:0] fb_data;
  logic        frame_done;
  logic [15:0] frame_count;
  int checks = 0;
  int failures = 0;

  raymarch_scheduler #(.WIDTH(4), .HEIGHT(2)) dut (
    .clk_pixel_in(clk), .rst_in(rst), .enable_in(enable), .pixel_done_in(pixel_done),
    .red_in(red), .green_in(green), .blue_in(blue),
    .curr_x(curr_x), .curr_y(curr_y), .fb_we_out(fb_we), .fb_addr_out(fb_addr),
    .fb_data_out(fb_data), .frame_done_out(frame_done), .frame_count_out(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic pd, input logic [23:0] rgb);
    @(negedge clk);
    pixel_done = pd;
    {red, green, blue} = rgb;
    @(posedge clk);
    #1;
    pixel_done = 1'b0;
  endtask

  function automatic logic [15:0] rgb565(input logic [7:0] c);
    return {c[7:3], c[7:2], c[7:3]};
  endfunction

  task automatic px(input int a, input logic [7:0] c);
    int n;
    n = (a + 1) % 8;
    tick(1'b1, {c, c, c});
    chk("px_we", fb_we, 1);
    chk("px_addr", fb_addr, a);
    chk("px_data", fb_data, rgb565(c));
    chk("px_fdone", frame_done, a == 7);
    chk("px_x", curr_x, n % 4);
    chk("px_y", curr_y, n / 4);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_we"}, fb_we, 0);
    chk({tag, "_fdone"}, frame_done, 0);
    chk({tag, "_x"}, curr_x, 0);
    chk({tag, "_y"}, curr_y, 0);
  endtask

  initial begin
    enable = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst_we", fb_we, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_data", fb_data, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_count", frame_count, 0);
    chk("rst_x", curr_x, 0);
    chk("rst_y", curr_y, 0);
    @(negedge clk) rst = 1'b0;

    tick(1'b1, 24'h123456);
    idle_chk("prime");
    for (int k = 1; k <= 8; k++) begin
      px(k - 1, 8'(k * 32));
      if (k == 1) chk("data_k1", fb_data, 16'h2104);
      tick(1'b0, 24'h0);
      chk("gap_we", fb_we, 0);
      chk("gap_fdone", frame_done, 0);
    end
    chk("count_f1", frame_count, 1);

    for (int a = 0; a < 8; a++) begin
      if (a == 3) enable = 1'b0;
      px(a, 8'(a * 16 + 5));
    end
    chk("count_f2", frame_count, 2);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 24'hABCDEF);
      idle_chk("hold");
    end
    enable = 1'b1;
    tick(1'b0, 24'h0);
    idle_chk("hold_exit");
    for (int a = 0; a < 8; a++) px(a, 8'hA0 + 8'(a));
    chk("count_f3", frame_count, 3);

    for (int a = 0; a < 6; a++) px(a, 8'(a * 40 + 9));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we", fb_we, 0);
    chk("mid_rst_addr", fb_addr, 0);
    chk("mid_rst_data", fb_data, 0);
    chk("mid_rst_count", frame_count, 0);
    chk("mid_rst_x", curr_x, 0);
    chk("mid_rst_y", curr_y, 0);
    @(negedge clk) rst = 1'b0;
    tick(1'b1, 24'hFFFFFF);
    idle_chk("reprime");
    for (int a = 0; a < 8; a++) px(a, 8'h55 + 8'(a));
    chk("count_after_rst", frame_count, 1);

    @(negedge clk);
    force dut.frame_count_out = 16'hFFFE;
    #1 release dut.frame_count_out;
    for (int a = 0; a < 8; a++) px(a, 8'hF0 - 8'(a));
    chk("count_ffff", frame_count, 16'hFFFF);
    for (int a = 0; a < 8; a++) px(a, 8'h0F + 8'(a));
    chk("count_wrap", frame_count, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/raymarch_scheduler.md
RAYMARCH_SCHEDULER -- requirements
Module: raymarch_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 1280, meaning the horizontal pixel count.
REQ-002 SHALL have parameter HEIGHT, default 720, meaning the vertical pixel count.
REQ-003 SHALL have port clk_pixel_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port enable_in, input, 1 bit: frame-level run enable, sampled only at frame boundaries and in HOLD.
REQ-006 SHALL have port pixel_done_in, input, 1 bit: raymarcher completion; each cycle high is one completed pixel.
REQ-007 SHALL have ports red_in, green_in, blue_in, input, 8 bits each: raymarcher colour, valid in any cycle pixel_done_in is high.
REQ-008 SHALL have port curr_x, output, $clog2(WIDTH) bits: the pixel column driven to the raymarcher.
REQ-009 SHALL have port curr_y, output, $clog2(HEIGHT) bits: the pixel row driven to the raymarcher.
REQ-010 SHALL have port fb_we_out, output, 1 bit: framebuffer write strobe, one cycle per pixel.
REQ-011 SHALL have port fb_addr_out, output, $clog2(WIDTH*HEIGHT) bits: linear write address y*WIDTH+x.
REQ-012 SHALL have port fb_data_out, output, 16 bits: RGB565 pixel {red_in[7:3], green_in[7:2], blue_in[7:3]}.
REQ-013 SHALL have port frame_done_out, output, 1 bit: one-cycle pulse coincident with the write of the last pixel of a frame.
REQ-014 SHALL have port frame_count_out, output, 16 bits: completed frames, wrapping 0xFFFF->0.

Function
REQ-015 SHALL implement states PRIME, RUN, HOLD.
REQ-016 PRIME SHALL hold coordinates at (0,0), discard the first pixel_done_in (stale post-reset colour), then go to RUN if enable_in=1, else HOLD.
REQ-017 RUN SHALL, on each pixel_done_in cycle, register fb_we_out=1, fb_addr_out, and fb_data_out for the current (curr_x,curr_y) and colour, visible the next cycle (latency 1).
REQ-018 fb_we_out and frame_done_out SHALL be low in every cycle not following a RUN-state pixel_done_in.
REQ-019 On the clock edge ending a RUN pixel_done_in cycle, coordinates SHALL advance, so the raymarcher samples the new pixel in the following cycle.
REQ-020 Advance: x+1; at x=WIDTH-1, x->0 and y+1; at (WIDTH-1,HEIGHT-1), the next pixel SHALL be (0,0).
REQ-021 fb_addr SHALL be maintained as an incrementing counter (no multiplier), reset to 0 at frame wrap, and SHALL always equal y*WIDTH+x of the written pixel.
REQ-022 At the last pixel of a frame: frame_done_out SHALL pulse with that write, frame_count_out SHALL increment in the same edge, and the state SHALL go to HOLD if enable_in=0, else remain RUN.
REQ-023 Mid-frame deassertion of enable_in SHALL have no effect until the frame completes.
REQ-024 HOLD SHALL keep coordinates at (0,0), ignore pixel_done_in (no writes), and go to RUN on the first cycle enable_in=1.
REQ-025 After HOLD->RUN, the next pixel_done_in SHALL be written as pixel (0,0).
REQ-026 pixel_done_in high on consecutive cycles SHALL be treated as consecutive distinct pixels with no loss.

Reset
REQ-027 Asserting rst_in SHALL immediately and asynchronously set state=PRIME, curr_x=0, curr_y=0, address=0, fb_we_out=0, fb_addr_out=0, fb_data_out=0, frame_done_out=0, and frame_count_out=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no further writes; after release, the block SHALL restart from PRIME.

Verification (WIDTH=4, HEIGHT=2)
REQ-029 Reset release, enable_in=1, first pulse with colour 0x123456 -> no write; coords stay (0,0); state RUN.
REQ-030 8 pulses, pulse k with colour RGB=(k*32,k*32,k*32) -> writes to addresses 0..7 in order, data matching REQ-012 (k=1: 0x2104); coords sequence (1,0),(2,0),(3,0),(0,1)...(0,0); frame_done_out high only with address 7; frame_count_out=1.
REQ-031 enable_in dropped at pixel 3, 5 more pulses -> frame completes (address 7 written), state HOLD; 3 further pulses produce no writes, coords (0,0); enable_in=1 then a pulse -> write to address 0.
REQ-032 Pulses on 8 consecutive cycles -> 8 writes on 8 consecutive cycles, addresses 0..7, one frame_done_out.
REQ-033 rst_in asserted asynchronously between edges at address 5 -> outputs zero before the next edge; the first pulse after release is discarded; the next pulse writes address 0.
REQ-034 frame_count_out preloaded via 65536 frames, or forced near wrap -> 0xFFFF then 0x0000.
